// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debounce and a two-digit key history.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key every REPEAT_CYCLES clocks.
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int DW_W = $clog2(SCAN_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RPT_LAST = RP_W'(REPEAT_CYCLES - 1);
`endif

  if (SCAN_CYCLES < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("keypad_scan_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  logic [3:0]      col_p0, col_p1, col_s;
  state_t          state_q, state_nxt;
  logic [3:0]      row_nxt, row_rot;
  logic [DW_W-1:0] dwell_q, dwell_nxt;
  logic [DB_W-1:0] cnt_q, cnt_nxt;
  logic [3:0]      lat_col_q, lat_col_nxt;
  logic            accept;
  logic [3:0]      code;
  logic            key_valid_nxt, key_held_nxt;
  logic [3:0]      key_code_nxt, digit_new_nxt, digit_old_nxt;
`ifdef KEYPAD_REPEAT_EN
  logic [RP_W-1:0] rpt_q, rpt_nxt;
`endif

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0010: oh2idx = 2'd1;
      4'b0100: oh2idx = 2'd2;
      4'b1000: oh2idx = 2'd3;
      default: oh2idx = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:    keymap = 4'h1;
      4'd1:    keymap = 4'h2;
      4'd2:    keymap = 4'h3;
      4'd3:    keymap = 4'hA;
      4'd4:    keymap = 4'h4;
      4'd5:    keymap = 4'h5;
      4'd6:    keymap = 4'h6;
      4'd7:    keymap = 4'hB;
      4'd8:    keymap = 4'h7;
      4'd9:    keymap = 4'h8;
      4'd10:   keymap = 4'h9;
      4'd11:   keymap = 4'hC;
      4'd12:   keymap = 4'hE;
      4'd13:   keymap = 4'h0;
      4'd14:   keymap = 4'hF;
      default: keymap = 4'hD;
    endcase
  endfunction

  // stage p0/p1: two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_p0 <= '0;
      col_p1 <= '0;
    end else begin
      col_p0 <= col;
      col_p1 <= col_p0;
    end
  end

  assign col_s   = col_p1;
  assign row_rot = {row[2:0], row[3]};
  assign code    = keymap(oh2idx(row), oh2idx(lat_col_q));

  always_comb begin
    state_nxt     = state_q;
    row_nxt       = row;
    dwell_nxt     = dwell_q;
    cnt_nxt       = cnt_q;
    lat_col_nxt   = lat_col_q;
    accept        = 1'b0;
    key_valid_nxt = 1'b0;
    key_code_nxt  = key_code;
    digit_new_nxt = digit_new;
    digit_old_nxt = digit_old;
`ifdef KEYPAD_REPEAT_EN
    rpt_nxt       = rpt_q;
`endif
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_nxt = '0;
          if ($onehot(col_s)) begin
            lat_col_nxt = col_s;
            cnt_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end else begin
            row_nxt = row_rot;
          end
        end else begin
          dwell_nxt = dwell_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s != lat_col_q) begin
          state_nxt = SCAN;
          row_nxt   = row_rot;
          dwell_nxt = '0;
        end else if (cnt_q == DB_LAST) begin
          state_nxt = HELD;
          accept    = 1'b1;
`ifdef KEYPAD_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if ((col_s & lat_col_q) == 4'b0000) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        // a repeat that would land right after another pulse waits one cycle
        else if (rpt_q >= RPT_LAST) begin
          if (!key_valid) begin
            accept  = 1'b1;
            rpt_nxt = '0;
          end
        end else begin
          rpt_nxt = rpt_q + 1'b1;
        end
`else
        // without auto-repeat a held key simply waits for its release
`endif
      end
      default: begin
        if ((col_s & lat_col_q) != 4'b0000) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_nxt = SCAN;
          row_nxt   = row_rot;
          dwell_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
    endcase
    if (accept) begin
      key_valid_nxt = 1'b1;
      key_code_nxt  = code;
      digit_old_nxt = digit_new;
      digit_new_nxt = code;
    end
    key_held_nxt = (state_nxt == HELD) || (state_nxt == RELEASE);
  end

  // stage p2: FSM state, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN;
      row       <= 4'b0001;
      dwell_q   <= '0;
      cnt_q     <= '0;
      lat_col_q <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      digit_new <= '0;
      digit_old <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_nxt;
      row       <= row_nxt;
      dwell_q   <= dwell_nxt;
      cnt_q     <= cnt_nxt;
      lat_col_q <= lat_col_nxt;
      key_valid <= key_valid_nxt;
      key_code  <= key_code_nxt;
      key_held  <= key_held_nxt;
      digit_new <= digit_new_nxt;
      digit_old <= digit_old_nxt;
`ifdef KEYPAD_REPEAT_EN
      rpt_q     <= rpt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized bench for keypad_scan_ctrl against a keypad-level reference model.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

  localparam int SCAN = 4;
  localparam int DEB  = 8;
  localparam int RPT  = 32;

  localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, KA = 16'h0008, K5 = 16'h0020;
  localparam logic [15:0] K7 = 16'h0100, K9 = 16'h0400, KF = 16'h4000, KD = 16'h8000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col = 4'b0000;
  logic [3:0] row, key_code, digit_new, digit_old;
  logic       key_valid, key_held;

  keypad_scan_ctrl #(
    .SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_valid(key_valid),
    .key_code(key_code), .key_held(key_held), .digit_new(digit_new), .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: keypad behaviour in terms of scan position, mode and run lengths.
  int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int mstage;                 // 0 scanning, 1 confirming press, 2 held, 3 confirming release
  int scan_pos;               // row * SCAN + dwell while scanning
  int run, rpt, lat_r, lat_c;
  logic [3:0] sync0, sync1;
  logic       e_valid;
  logic [3:0] e_code, e_new, e_old;

  task automatic model_reset();
    mstage = 0; scan_pos = 0; run = 0; rpt = 0; lat_r = 0; lat_c = 0;
    sync0 = '0; sync1 = '0;
    e_valid = 1'b0; e_code = '0; e_new = '0; e_old = '0;
  endtask

  task automatic accept_key();
    e_valid = 1'b1;
    e_code  = 4'(kmap[lat_r * 4 + lat_c]);
    e_old   = e_new;
    e_new   = e_code;
  endtask

  function automatic logic [3:0] exp_row();
    if (mstage == 0) return 4'b0001 << (scan_pos / SCAN);
    return 4'b0001 << lat_r;
  endfunction

  task automatic model_step(input logic [3:0] c);
    logic [3:0] cs;
    cs = sync1;
    e_valid = 1'b0;
    case (mstage)
      0: begin
        if (scan_pos % SCAN == SCAN - 1) begin
          if ($countones(cs) == 1) begin
            lat_r = scan_pos / SCAN;
            for (int b = 0; b < 4; b++) if (cs[b]) lat_c = b;
            mstage = 1; run = 0;
          end else begin
            scan_pos = (scan_pos + 1) % (4 * SCAN);
          end
        end else begin
          scan_pos++;
        end
      end
      1: begin
        if (cs != (4'b0001 << lat_c)) begin
          mstage = 0; scan_pos = ((lat_r + 1) % 4) * SCAN;
        end else begin
          run++;
          if (run == DEB) begin mstage = 2; rpt = 0; accept_key(); end
        end
      end
      2: begin
        if (!cs[lat_c]) begin
          mstage = 3; run = 0;
        end
`ifdef KEYPAD_REPEAT_EN
        else begin
          rpt++;
          if (rpt == RPT) begin rpt = 0; accept_key(); end
        end
`endif
      end
      default: begin
        if (cs[lat_c]) begin
          mstage = 2; run = 0;
        end else begin
          run++;
          if (run == DEB) begin mstage = 0; scan_pos = ((lat_r + 1) % 4) * SCAN; end
        end
      end
    endcase
    sync1 = sync0;
    sync0 = c;
  endtask

  function automatic logic [3:0] keys_to_col(input logic [15:0] k, input logic [3:0] r);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) if (r[i]) c |= k[i*4 +: 4];
    return c;
  endfunction

  task automatic compare_all();
    chk("row", 32'(row), 32'(exp_row()));
    chk("key_valid", 32'(key_valid), 32'(e_valid));
    chk("key_code", 32'(key_code), 32'(e_code));
    chk("key_held", 32'(key_held), 32'(mstage >= 2));
    chk("digit_new", 32'(digit_new), 32'(e_new));
    chk("digit_old", 32'(digit_old), 32'(e_old));
  endtask

  // One clock: drive columns from pressed keys and the currently driven row, then check.
  task automatic step(input logic [15:0] keys);
    col = keys_to_col(keys, exp_row());
    @(posedge clk);
    model_step(col);
    @(negedge clk);
    compare_all();
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic steps(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) step(keys);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    compare_all();

    // idle scanning
    pulses = 0;
    steps('0, 40);
    chk("t1_pulses", 32'(pulses), 32'd0);

    // clean press of 5, then release; scanning resumes on the row after it
    pulses = 0;
    steps(K5, 100);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step('0);
      if (key_held === 1'b0) found = 1;
    end
    chk("t2_release_seen", 32'(found), 32'd1);
    chk("t2_row_resume", 32'(row), 32'b0100);
    steps('0, 20);
    chk("t2_pulses", 32'(pulses), 32'd1);
    chk("t2_code", 32'(key_code), 32'h5);
    chk("t2_new", 32'(digit_new), 32'h5);
    chk("t2_old", 32'(digit_old), 32'h0);

    // bouncing A, then steady
    pulses = 0;
    for (int i = 0; i < 30; i++) step(((i / 3) % 2 == 0) ? KA : 16'h0);
    chk("t3_bounce_pulses", 32'(pulses), 32'd0);
    steps(KA, 60);
    steps('0, 40);
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_code", 32'(key_code), 32'hA);

    // two columns on one row, rollover rejection, then D
    pulses = 0;
    steps(K1 | K2, 40);
    chk("t4_multi_pulses", 32'(pulses), 32'd0);
    steps(K1, 40);
    steps(K1 | K9, 40);
    steps('0, 40);
    steps(KD, 60);
    steps('0, 40);
    chk("t4_pulses", 32'(pulses), 32'd2);
    chk("t4_old", 32'(digit_old), 32'h1);
    chk("t4_new", 32'(digit_new), 32'hD);

    // asynchronous reset in the middle of a debounce
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(K7);
      if (mstage == 1) found = 1;
    end
    chk("t5_debounce_entry", 32'(found), 32'd1);
    steps(K7, 4);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_row", 32'(row), 32'b0001);
    chk("t5_valid", 32'(key_valid), 32'd0);
    chk("t5_code", 32'(key_code), 32'd0);
    chk("t5_held", 32'(key_held), 32'd0);
    chk("t5_new", 32'(digit_new), 32'd0);
    chk("t5_old", 32'(digit_old), 32'd0);
    col = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    pulses = 0;
    steps('0, 40);
    chk("t5_pulses", 32'(pulses), 32'd0);

    // long hold of F
    pulses = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(KF);
      if (key_valid === 1'b1) found = 1;
    end
    chk("t6_first", 32'(found), 32'd1);
    steps(KF, 100);
    steps('0, 40);
`ifdef KEYPAD_REPEAT_EN
    chk("t6_pulses", 32'(pulses), 32'd4);
`else
    chk("t6_pulses", 32'(pulses), 32'd1);
`endif
    chk("t6_code", 32'(key_code), 32'hF);

    // random presses, chords, bounces and idle gaps
    for (int s = 0; s < 16; s++) begin
      int kind, len;
      logic [15:0] m;
      kind = $urandom_range(0, 3);
      len  = $urandom_range(5, 60);
      m = '0;
      if (kind != 0) m[$urandom_range(0, 15)] = 1'b1;
      if (kind == 2) m[$urandom_range(0, 15)] = 1'b1;
      for (int i = 0; i < len; i++) begin
        if (kind == 3 && ($urandom_range(0, 3) == 0)) step('0);
        else step(m);
      end
    end
    steps('0, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
